// File: rtl/motion_filter.sv
// motion_filter: removes a calibrated zero offset from x/y/z samples, block-averages, scales and saturates them.
// Optional DEADBAND_EN macro: zeroes small offset-corrected samples before averaging.
module motion_filter #(
  parameter int CAL_LOG2    = 3,
  parameter int AVG_LOG2    = 2,
  parameter int SCALE_SHIFT = 4,
  parameter int OUT_W       = 10,
  parameter int DEADBAND    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic signed [15:0]      x_in,
  input  logic signed [15:0]      y_in,
  input  logic signed [15:0]      z_in,
  input  logic                    recal,
  output logic signed [OUT_W-1:0] x_feed,
  output logic signed [OUT_W-1:0] y_feed,
  output logic signed [OUT_W-1:0] z_feed,
  output logic                    feed_valid,
  output logic                    calibrated
);
  localparam int CW = 16 + CAL_LOG2;
  localparam int AW = 16 + AVG_LOG2;
  localparam logic signed [AW-1:0] OMAX = AW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [AW-1:0] OMIN = -OMAX - AW'(1);
  typedef enum logic [1:0] {CAL_CLEAR, CAL_ACC, RUN} state_t;
  state_t r_state, w_next;
  logic [CAL_LOG2-1:0] r_ccnt;
  logic [AVG_LOG2-1:0] r_acnt;
  logic signed [CW-1:0] r_cacc [3];
  logic signed [AW-1:0] r_aacc [3];
  logic signed [15:0] r_off [3];
  logic signed [OUT_W-1:0] r_feed [3];
  logic r_fv;
  logic signed [15:0] w_in [3];
  logic signed [CW-1:0] w_csum [3];
  logic signed [16:0] w_diff [3];
  logic signed [15:0] w_corr [3];
  logic signed [15:0] w_db [3];
  logic signed [AW-1:0] w_asum [3];
  logic signed [AW-1:0] w_val [3];
  logic signed [OUT_W-1:0] w_sat [3];
  logic w_take, w_cal_last, w_blk_last;
`ifdef DEADBAND_EN
  localparam logic signed [15:0] DB = 16'(DEADBAND);
`endif
  assign w_take     = sample_valid && !recal;
  assign w_cal_last = w_take && r_state == CAL_ACC && &r_ccnt;
  assign w_blk_last = w_take && r_state == RUN && &r_acnt;
  // per-axis datapath: calibration sum, offset correction with 16-bit saturation, block sum, scale and output saturation
  always_comb begin
    w_in[0] = x_in;
    w_in[1] = y_in;
    w_in[2] = z_in;
    for (int i = 0; i < 3; i++) begin
      w_csum[i] = r_cacc[i] + CW'(w_in[i]);
      w_diff[i] = 17'(w_in[i]) - 17'(r_off[i]);
      w_corr[i] = (w_diff[i][16] != w_diff[i][15]) ? (w_diff[i][16] ? 16'sh8000 : 16'sh7fff) : w_diff[i][15:0];
`ifdef DEADBAND_EN
      w_db[i] = (w_corr[i] > -DB && w_corr[i] < DB) ? 16'sd0 : w_corr[i];
`else
      w_db[i] = w_corr[i];
`endif
      w_asum[i] = r_aacc[i] + AW'(w_db[i]);
      w_val[i]  = w_asum[i] >>> (AVG_LOG2 + SCALE_SHIFT);
      w_sat[i]  = w_val[i] > OMAX ? OUT_W'(OMAX) : w_val[i] < OMIN ? OUT_W'(OMIN) : OUT_W'(w_val[i]);
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= CAL_CLEAR;
    else r_state <= w_next;
  end
  // next state: recal always restarts calibration, which lasts one clear cycle plus 2^CAL_LOG2 samples
  always_comb begin
    w_next = recal ? CAL_CLEAR : r_state == CAL_CLEAR ? CAL_ACC : w_cal_last ? RUN : r_state;
  end
  // outputs: offsets are valid only in RUN
  always_comb begin
    calibrated = r_state == RUN;
    feed_valid = r_fv;
    x_feed     = r_feed[0];
    y_feed     = r_feed[1];
    z_feed     = r_feed[2];
  end
  // accumulators, counters, offsets and feeds; CAL_CLEAR also discards any partial average block
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ccnt <= '0;
      r_acnt <= '0;
      r_fv   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_cacc[i] <= '0;
        r_aacc[i] <= '0;
        r_off[i]  <= '0;
        r_feed[i] <= '0;
      end
    end else begin
      r_fv <= w_blk_last;
      if (r_state == CAL_CLEAR) begin
        r_ccnt <= '0;
        r_acnt <= '0;
      end else if (w_take && r_state == CAL_ACC) r_ccnt <= r_ccnt + 1'b1;
      else if (w_take && r_state == RUN) r_acnt <= r_acnt + 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (r_state == CAL_CLEAR) begin
          r_cacc[i] <= '0;
          r_aacc[i] <= '0;
        end else if (w_take && r_state == CAL_ACC) begin
          r_cacc[i] <= w_cal_last ? '0 : w_csum[i];
          if (w_cal_last) r_off[i] <= 16'(w_csum[i] >>> CAL_LOG2);
        end else if (w_take && r_state == RUN) begin
          r_aacc[i] <= w_blk_last ? '0 : w_asum[i];
          if (w_blk_last) r_feed[i] <= w_sat[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_motion_filter.sv
// tb_motion_filter: directed stimulus with a scoreboard queue; a monitor checks every feed_valid pulse.
module tb_motion_filter;
`ifdef DEADBAND_EN
  localparam int SS = 0;
  localparam int DB = 128;
`else
  localparam int SS = 4;
  localparam int DB = 8;
`endif
  typedef struct {int x; int y; int z;} exp_t;
  logic clk = 0, rst = 0, sample_valid = 0, recal = 0;
  logic signed [15:0] x_in = 0, y_in = 0, z_in = 0;
  logic signed [9:0] x_feed, y_feed, z_feed;
  logic feed_valid, calibrated;
  int n_cmp = 0, n_bad = 0, n_pulses = 0, n_exp = 0;
  exp_t q[$];

  motion_filter #(.SCALE_SHIFT(SS), .DEADBAND(DB)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .recal(recal),
    .x_feed(x_feed), .y_feed(y_feed), .z_feed(z_feed),
    .feed_valid(feed_valid), .calibrated(calibrated)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(int x, int y, int z);
    sample_valid = 1;
    x_in = 16'(x);
    y_in = 16'(y);
    z_in = 16'(z);
    @(negedge clk);
    sample_valid = 0;
  endtask

  task automatic expect_out(int x, int y, int z);
    q.push_back('{x, y, z});
    n_exp++;
  endtask

  task automatic cal(int x, int y, int z);
    recal = 1;
    @(negedge clk);
    recal = 0;
    chk("cal_drop", calibrated, 0);
    @(negedge clk);
    repeat (7) send(x, y, z);
    chk("cal_before_8th", calibrated, 0);
    send(x, y, z);
    chk("cal_after_8th", calibrated, 1);
  endtask

  task automatic block(int x, int y, int z);
    repeat (3) send(x, y, z);
    chk("no_early_feed", q.size(), 1);
    send(x, y, z);
    repeat (2) @(negedge clk);
    chk("feed_seen", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst && feed_valid) begin
      n_pulses++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_feed_valid: got 1, expected 0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("x_feed", x_feed, e.x);
        chk("y_feed", y_feed, e.y);
        chk("z_feed", z_feed, e.z);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_x", x_feed, 0);
    chk("rst_fv", feed_valid, 0);
    chk("rst_cal", calibrated, 0);
    rst = 1;
`ifdef DEADBAND_EN
    cal(0, 0, 0);
    expect_out(0, -128, 0);
    block(100, -128, 127);
    expect_out(128, 0, 200);
    block(128, -127, 200);
    expect_out(0, 0, -128);
    block(-127, 0, -128);
`else
    cal(100, -50, 256);
    expect_out(10, -20, 0);
    block(260, -370, 256);
    send(999, 999, 999);
    send(999, 999, 999);
    cal(0, 0, 0);
    chk("hold_x", x_feed, 10);
    chk("hold_y", y_feed, -20);
    expect_out(-2, 2, 62);
    block(-17, 40, 1000);
    cal(0, 0, 0);
    expect_out(511, -512, 0);
    block(32767, -32768, 0);
    cal(-100, 100, 5);
    expect_out(511, -512, 7);
    block(32767, -32868 + 100, 117);
    recal = 1;
    @(negedge clk);
    recal = 0;
    @(negedge clk);
    repeat (7) send(-8, 16, 0);
    recal = 1;
    sample_valid = 1;
    @(negedge clk);
    recal = 0;
    chk("collision_cal", calibrated, 0);
    x_in = 9999;
    y_in = 9999;
    z_in = 9999;
    @(negedge clk);
    repeat (7) send(-8, 16, 0);
    chk("tp_before_8th", calibrated, 0);
    send(-8, 16, 0);
    chk("tp_after_8th", calibrated, 1);
    expect_out(-2, 10, -1);
    repeat (4) send(-25, 176, -16);
    repeat (2) @(negedge clk);
    chk("tp_feed_seen", q.size(), 0);
`endif
    send(0, 0, 0);
    send(0, 0, 0);
    rst = 0;
    #1;
    chk("midrst_x", x_feed, 0);
    chk("midrst_y", y_feed, 0);
    chk("midrst_z", z_feed, 0);
    chk("midrst_fv", feed_valid, 0);
    chk("midrst_cal", calibrated, 0);
    @(negedge clk);
    rst = 1;
    repeat (8) send(0, 0, 0);
    chk("rst_clear_cycle", calibrated, 0);
    send(0, 0, 0);
    chk("rst_recal_done", calibrated, 1);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("pulse_count", n_pulses, n_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
